dp_pipe_ctrl: RTL
=================

Name: dp_pipe_ctrl

Overview:
Elastic pipeline controller for the multi-precision dot-product datapath (multiplier stages, L1 adder stage, L2 adder/normalise stages).
- Carries one valid bit plus sideband (mode, first, last) per stage.
- Generates per-stage register enables and collapses bubbles.
- Provides valid/ready handshakes at input and output.
- Tracks vector boundaries so the downstream accumulator knows when to clear and when a result is final.

Parameters:
STAGES, 4, number of registered datapath stages controlled (>=2)
CNT_W, 8, width of beat counter within one vector
MODE_W, 2, width of precision-mode code carried with each beat

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream beat (4 operand pairs) available
in_ready  output  1  controller accepts beat this cycle
in_last  input  1  beat is final beat of current vector
in_mode  input  MODE_W  precision mode of beat
stage_en  output  STAGES  register-load enable for datapath stage i
stage_vld  output  STAGES  valid bit held in stage i
acc_clear  output  1  final-stage beat is first of its vector; accumulator must load, not add
acc_en  output  1  final-stage beat transfers to accumulator this cycle
out_valid  output  1  final stage holds a valid beat
out_ready  input  1  downstream accepts final-stage beat
out_last  output  1  final-stage beat is last of its vector
out_mode  output  MODE_W  mode of final-stage beat
vec_cnt  output  CNT_W  beats accepted so far in the open vector
mode_err  output  1  sticky: mode changed inside a vector
busy  output  1  any stage_vld set, or a vector open
stall_cnt  output  16  perf counter; see Optional Feature

Behaviour:
- Reset: all stage_vld, sideband, vec_cnt, mode_err and stall_cnt = 0; vector_open = 0.
- Reset effects while rst is high: in_ready = 1 (all stages empty), out_valid = 0, acc_en = 0, acc_clear = 0, busy = 0. Reset mid-operation drops all in-flight beats without any output transfer.
- Ready chain (combinational):
  - rdy[S-1] = ~vld[S-1] | out_ready.
  - rdy[i] = ~vld[i] | rdy[i+1].
  - in_ready = rdy[0].
- Stage enables: stage_en[i] = rdy[i].
- Stage loads on stage_en[i]:
  - Stage 0: vld[0] <= in_valid, with sideband {in_mode, first, in_last}.
  - Stage i>0: vld[i] <= vld[i-1], with sideband copied from stage i-1.
- Bubbles: empty stages fill even while the output is stalled.
- Latency: 4 cycles with no stalls (STAGES cycles in general) from in_valid&in_ready to out_valid. Throughput is 1 beat/cycle.
- Output side:
  - out_valid = vld[S-1].
  - acc_en = out_valid & out_ready.
  - acc_clear = out_valid & first[S-1].
  - out_last and out_mode come from stage S-1 sideband.
- Vector tracking, on accepted beat (in_valid & in_ready):
  - first = ~vector_open.
  - If in_last: vector_open <= 0, vec_cnt <= 0.
  - Otherwise: vector_open <= 1, vec_cnt <= vec_cnt+1, saturating at all-ones with no wrap.
  - Single-beat vector (first & last): acc_clear and out_last are both set on the same output beat.
- Mode checking:
  - Mode is latched on the first beat.
  - If a later beat of the same vector presents a different in_mode, mode_err <= 1 (sticky until rst). The beat is still accepted and carries its own mode.
- Inputs not accepted (in_valid low or in_ready low) change no state except stall_cnt.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: every stage shifts and the new beat is accepted in the same cycle.
- busy = |vld | vector_open.

Optional Feature:
DP_CTRL_PERF_EN
- Defined: stall_cnt increments (saturating at 16'hFFFF) every cycle where out_valid & ~out_ready. It is cleared by rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then one beat (in_last=1, mode=2) with out_ready=1 -> out_valid exactly 4 cycles later with acc_clear=1, out_last=1, out_mode=2, acc_en=1; busy falls the next cycle.
- Stream 8 consecutive beats forming a vector (last on beat 8) with out_ready=1 -> in_ready constant 1; vec_cnt reads 1..7 then 0; acc_clear only on output beat 1; out_last only on output beat 8.
- Fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0 once all 4 stages are valid; no output beat is lost or duplicated; stall_cnt=5 when DP_CTRL_PERF_EN is defined, 0 otherwise.
- Inject a bubble (in_valid=0 for one cycle) while out_ready=0 -> the bubble is collapsed; in_ready stays 1 until all 4 stage_vld are 1.
- Vector with mode 1 on beat 1 and mode 3 on beat 2 -> mode_err=1 after beat 2 and stays set across later vectors; output beats carry modes 1 and 3.
- Assert rst with 3 beats in flight -> all stage_vld=0 and vec_cnt=0 next cycle; no acc_en pulse; the next accepted beat has acc_clear=1.

Source files
------------

// File: rtl/dp_pipe_ctrl_if.sv
// Beat handshake bundle for the dot-product pipeline controller: upstream beat
// input side and the final-stage output side.
interface dp_pipe_ctrl_if #(
    parameter int MODE_W = 2
);
    // A beat moves on either side only in a cycle where valid and ready are
    // both high. Valid never depends on ready, and a valid beat holds its
    // payload until it is taken.
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [MODE_W-1:0] out_mode;

    modport master (
        output in_valid, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_last, out_mode
    );

    modport slave (
        input  in_valid, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_last, out_mode
    );
endinterface

// File: rtl/dp_pipe_ctrl.sv
// Elastic pipeline controller for the dot-product datapath: per-stage valid and
// sideband, bubble-collapsing enables and vector tracking. DP_CTRL_PERF_EN adds a stall counter.
module dp_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 8,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    dp_pipe_ctrl_if.slave     bus,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_vld,
    output logic              acc_clear,
    output logic              acc_en,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic              mode_err,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    logic [STAGES-1:0]             vld_q, vld_d;
    logic [STAGES-1:0]             first_q, first_d;
    logic [STAGES-1:0]             last_q, last_d;
    logic [STAGES-1:0][MODE_W-1:0] mode_q, mode_d;
    logic                          vec_open_q, vec_open_d;
    logic [CNT_W-1:0]              vec_cnt_q, vec_cnt_d;
    logic [MODE_W-1:0]             vec_mode_q, vec_mode_d;
    logic                          mode_err_q, mode_err_d;

    logic [STAGES-1:0] rdy;
    logic              accept;
    logic              out_vld;

    // A stage can load when it is empty or its occupant moves on this cycle.
    always_comb begin : ready_chain
        logic carry;
        rdy   = '0;
        carry = ~vld_q[STAGES-1] | bus.out_ready;
        rdy[STAGES-1] = carry;
        for (int i = STAGES - 2; i >= 0; i--) begin
            carry  = ~vld_q[i] | carry;
            rdy[i] = carry;
        end
    end

    assign accept = bus.in_valid & rdy[0];

    always_comb begin : next_state
        vld_d      = vld_q;
        first_d    = first_q;
        last_d     = last_q;
        mode_d     = mode_q;
        vec_open_d = vec_open_q;
        vec_cnt_d  = vec_cnt_q;
        vec_mode_d = vec_mode_q;
        mode_err_d = mode_err_q;

        for (int i = STAGES - 1; i >= 1; i--) begin
            if (rdy[i]) begin
                vld_d[i]   = vld_q[i-1];
                first_d[i] = first_q[i-1];
                last_d[i]  = last_q[i-1];
                mode_d[i]  = mode_q[i-1];
            end
        end
        if (rdy[0]) begin
            vld_d[0]   = bus.in_valid;
            first_d[0] = ~vec_open_q;
            last_d[0]  = bus.in_last;
            mode_d[0]  = bus.in_mode;
        end

        if (accept) begin
            if (vec_open_q && (bus.in_mode != vec_mode_q)) begin
                mode_err_d = 1'b1;
            end
            if (!vec_open_q) begin
                vec_mode_d = bus.in_mode;
            end
            if (bus.in_last) begin
                vec_open_d = 1'b0;
                vec_cnt_d  = '0;
            end else begin
                vec_open_d = 1'b1;
                vec_cnt_d  = (&vec_cnt_q) ? vec_cnt_q : vec_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            vld_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
            mode_q     <= '0;
            vec_open_q <= 1'b0;
            vec_cnt_q  <= '0;
            vec_mode_q <= '0;
            mode_err_q <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            first_q    <= first_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            vec_open_q <= vec_open_d;
            vec_cnt_q  <= vec_cnt_d;
            vec_mode_q <= vec_mode_d;
            mode_err_q <= mode_err_d;
        end
    end

    // Outputs are masked during reset so an in-flight beat never transfers.
    always_comb begin : outputs
        out_vld       = vld_q[STAGES-1] & ~rst;
        stage_en      = rdy;
        stage_vld     = vld_q;
        bus.in_ready  = rdy[0] | rst;
        bus.out_valid = out_vld;
        bus.out_last  = last_q[STAGES-1];
        bus.out_mode  = mode_q[STAGES-1];
        acc_en        = out_vld & bus.out_ready;
        acc_clear     = out_vld & first_q[STAGES-1];
        vec_cnt       = vec_cnt_q;
        mode_err      = mode_err_q;
        busy          = ((|vld_q) | vec_open_q) & ~rst;
    end

`ifdef DP_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin : stall_next
        stall_d = stall_q;
        if (out_vld && !bus.out_ready && !(&stall_q)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin : stall_reg
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
